// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I pipeline types and helpers.
//   control_t      decoded per-instruction control bundle
//   *_DEF          default sizing for the N-wide issue controller
//   stall_value()  cycles a writer's consumers must wait after issue
//   is_mem_op() / is_ctrl_flow()  resource classification helpers
// ---------------------------------------------------------------------------
package rv32i_pkg;

    localparam int unsigned NUM_REGS       = 32;
    localparam int unsigned ISSUE_W_DEF    = 2;
    localparam int unsigned LOAD_STALL_DEF = 1;
    localparam int unsigned ALU_STALL_DEF  = 0;

    typedef struct packed {
        logic reg_write;  // writes rd
        logic mem_read;   // load
        logic mem_write;  // store
        logic branch;     // conditional branch
        logic jump;       // JAL / JALR
        logic lui;        // LUI
        logic auipc;      // AUIPC
        logic system;     // ECALL / EBREAK / CSR
    } control_t;

    // Loads carry the load-use delay; every other register writer carries the
    // ALU delay. Non-writers never occupy a scoreboard entry.
    function automatic int unsigned stall_value(control_t c,
                                                int unsigned load_stall,
                                                int unsigned alu_stall);
        if (c.mem_read)  return load_stall;
        if (c.reg_write) return alu_stall;
        return 0;
    endfunction

    function automatic logic is_mem_op(control_t c);
        return c.mem_read | c.mem_write;
    endfunction

    function automatic logic is_ctrl_flow(control_t c);
        return c.branch | c.jump;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Per-register stall countdowns plus a load flag for the issue controller.
//   clk, rst        clock, asynchronous active-high reset
//   hold            freeze all state this cycle
//   set_en/rd/val/load  SET_PORTS write ports from issued writers
//   busy            per-register (cnt != 0)
//   load_pending    per-register "in-flight writer is a load"
// ---------------------------------------------------------------------------
module reg_scoreboard
    import rv32i_pkg::*;
#(
    parameter int unsigned SET_PORTS = 2,
    parameter int unsigned CNT_W     = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            hold,
    input  logic [SET_PORTS-1:0]            set_en,
    input  logic [SET_PORTS-1:0][4:0]       set_rd,
    input  logic [SET_PORTS-1:0][CNT_W-1:0] set_val,
    input  logic [SET_PORTS-1:0]            set_load,
    output logic [NUM_REGS-1:0]             busy,
    output logic [NUM_REGS-1:0]             load_pending
);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0]            load_flag;

    // NOTE: the scoreboard is a flop array, not a RAM, so every entry is
    // cleared by reset; a stale nonzero count would stall forever.
    // NOTE: state is written with non-blocking assignments so every entry
    // sees the pre-edge value of cnt and the set ports below simply win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            load_flag <= '0;
        end else if (!hold) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                    if (cnt[r] == CNT_W'(1)) begin
                        load_flag[r] <= 1'b0;
                    end
                end
            end
            // Later assignments override the decrement of the same entry.
            // Same-group writers to one rd never both issue, so ports never
            // collide.
            for (int p = 0; p < SET_PORTS; p++) begin
                if (set_en[p]) begin
                    cnt[set_rd[p]]       <= set_val[p];
                    load_flag[set_rd[p]] <= set_load[p];
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    assign load_pending = load_flag;

endmodule

// File: rtl/issue_ctrl_nw.sv
// ---------------------------------------------------------------------------
// issue_ctrl_nw
// N-wide in-order issue controller between decode slots and EX lanes.
// Slot 0 is oldest. Produces a prefix-contiguous issue vector.
//   clk, rst            clock, asynchronous active-high reset
//   valid_i, ctrl_i     per-slot valid and decoded control
//   rs1_i, rs2_i, rd_i  per-slot register indices
//   use_rs1_i/use_rs2_i per-slot operand-read flags
//   hold_i              backend frozen: no issue, scoreboard frozen
//   flush_i             redirect: no issue, scoreboard keeps counting
//   issue_o/issue_cnt_o per-slot grant and its popcount
//   stall_if_o          slot 0 valid but blocked by a hazard
//   busy_o              per-register scoreboard busy
//   stall_cycles_o      saturating count of stall_if_o cycles
// ---------------------------------------------------------------------------
module issue_ctrl_nw
    import rv32i_pkg::*;
#(
    parameter int unsigned ISSUE_W    = ISSUE_W_DEF,
    parameter int unsigned MEM_PORTS  = 1,
    parameter int unsigned LOAD_STALL = LOAD_STALL_DEF,
    parameter int unsigned ALU_STALL  = ALU_STALL_DEF,
    parameter int unsigned CNT_W      = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ISSUE_W-1:0]             valid_i,
    input  control_t [ISSUE_W-1:0]         ctrl_i,
    input  logic [ISSUE_W-1:0][4:0]        rs1_i,
    input  logic [ISSUE_W-1:0][4:0]        rs2_i,
    input  logic [ISSUE_W-1:0][4:0]        rd_i,
    input  logic [ISSUE_W-1:0]             use_rs1_i,
    input  logic [ISSUE_W-1:0]             use_rs2_i,
    input  logic                           hold_i,
    input  logic                           flush_i,
    output logic [ISSUE_W-1:0]             issue_o,
    output logic [$clog2(ISSUE_W+1)-1:0]   issue_cnt_o,
    output logic                           stall_if_o,
    output logic [31:0]                    busy_o,
    output logic [31:0]                    stall_cycles_o
);

    localparam int unsigned CW = $clog2(ISSUE_W + 1);

    // Per-slot qualified decode
    logic [ISSUE_W-1:0] rs1_used;
    logic [ISSUE_W-1:0] rs2_used;
    logic [ISSUE_W-1:0] writes;
    logic [ISSUE_W-1:0] mem_op;
    logic [ISSUE_W-1:0] cf_op;
    logic [ISSUE_W-1:0] sys_op;
    logic [ISSUE_W-1:0] lane0_only;

    // Hazard / resource results
    logic [ISSUE_W-1:0] reg_ok;
    logic [ISSUE_W-1:0] res_ok;
    logic [ISSUE_W-1:0] eligible;

    // Scoreboard interface
    logic [NUM_REGS-1:0]          busy;
    logic [ISSUE_W-1:0]           set_en;
    logic [ISSUE_W-1:0][4:0]      set_rd;
    logic [ISSUE_W-1:0][CNT_W-1:0] set_val;
    logic [ISSUE_W-1:0]           set_load;

    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            rs1_used[k]   = use_rs1_i[k] && (rs1_i[k] != 5'd0);
            rs2_used[k]   = use_rs2_i[k] && (rs2_i[k] != 5'd0);
            writes[k]     = ctrl_i[k].reg_write && (rd_i[k] != 5'd0);
            mem_op[k]     = valid_i[k] && is_mem_op(ctrl_i[k]);
            cf_op[k]      = valid_i[k] && is_ctrl_flow(ctrl_i[k]);
            sys_op[k]     = valid_i[k] && ctrl_i[k].system;
            lane0_only[k] = ctrl_i[k].lui || ctrl_i[k].auipc;
        end
    end

    // Register hazards: against in-flight writers (scoreboard) and against
    // older writers in the same group (no same-cycle forwarding, no WAW).
    // WAR inside a group is harmless because operands are read at issue.
    // NOTE: every always_comb output gets a default before any conditional
    // update, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        reg_ok = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            reg_ok[k] = 1'b1;
            if (rs1_used[k] && busy[rs1_i[k]]) reg_ok[k] = 1'b0;
            if (rs2_used[k] && busy[rs2_i[k]]) reg_ok[k] = 1'b0;
            if (writes[k]   && busy[rd_i[k]])  reg_ok[k] = 1'b0;
            for (int j = 0; j < k; j++) begin
                if (writes[j] && rs1_used[k] && (rd_i[j] == rs1_i[k])) reg_ok[k] = 1'b0;
                if (writes[j] && rs2_used[k] && (rd_i[j] == rs2_i[k])) reg_ok[k] = 1'b0;
                if (writes[j] && writes[k]   && (rd_i[j] == rd_i[k]))  reg_ok[k] = 1'b0;
            end
        end
    end

    // Structural limits over the prefix 0..k: memory ports, a single
    // control-flow op, LUI/AUIPC lane restriction, and SYSTEM as a barrier
    // for everything younger.
    always_comb begin
        int unsigned mem_seen;
        int unsigned cf_seen;
        logic        sys_older;
        res_ok    = '0;
        mem_seen  = 0;
        cf_seen   = 0;
        sys_older = 1'b0;
        for (int k = 0; k < ISSUE_W; k++) begin
            mem_seen  = mem_seen + 32'(mem_op[k]);
            cf_seen   = cf_seen + 32'(cf_op[k]);
            res_ok[k] = (mem_seen <= MEM_PORTS) && (cf_seen <= 1) && !sys_older
                        && !((k > 0) && lane0_only[k]);
            sys_older = sys_older || sys_op[k];
        end
    end

    // SYSTEM ops bypass register hazards but still obey structural limits.
    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            eligible[k] = valid_i[k] && res_ok[k] && (sys_op[k] || reg_ok[k]);
        end
    end

    // Prefix chain: a blocked slot starves every younger slot. Reset also
    // gates the chain so nothing issues in the reset cycle.
    always_comb begin
        logic grant;
        issue_o = '0;
        grant   = !rst && !hold_i && !flush_i;
        for (int k = 0; k < ISSUE_W; k++) begin
            issue_o[k] = grant && eligible[k];
            grant      = issue_o[k];
        end
    end

    always_comb begin
        issue_cnt_o = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            issue_cnt_o = issue_cnt_o + CW'(issue_o[k]);
        end
    end

    assign stall_if_o = !rst && !hold_i && !flush_i && valid_i[0] && !issue_o[0];

    // Zero-delay writers (stall value 0) never occupy an entry.
    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            set_en[k]   = issue_o[k] && writes[k]
                          && (stall_value(ctrl_i[k], LOAD_STALL, ALU_STALL) != 0);
            set_rd[k]   = rd_i[k];
            set_val[k]  = CNT_W'(stall_value(ctrl_i[k], LOAD_STALL, ALU_STALL));
            set_load[k] = ctrl_i[k].mem_read;
        end
    end

    reg_scoreboard #(
        .SET_PORTS (ISSUE_W),
        .CNT_W     (CNT_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold_i),
        .set_en       (set_en),
        .set_rd       (set_rd),
        .set_val      (set_val),
        .set_load     (set_load),
        .busy         (busy),
        .load_pending ()
    );

    assign busy_o = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_o <= '0;
        end else if (stall_if_o && (stall_cycles_o != 32'hFFFF_FFFF)) begin
            stall_cycles_o <= stall_cycles_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_issue_ctrl_nw.sv
// ---------------------------------------------------------------------------
// tb_issue_ctrl_nw
// Directed bench for issue_ctrl_nw: a 2-wide instance (LOAD_STALL=1) and a
// 4-wide instance (LOAD_STALL=2). Expected outputs are queued when a step is
// driven and popped/compared mid-cycle.
// ---------------------------------------------------------------------------
module tb_issue_ctrl_nw;
    import rv32i_pkg::*;

    typedef enum int {K_NOP, K_ADD, K_LW, K_SW, K_BEQ, K_JAL, K_LUI, K_ECALL} kind_e;

    typedef struct {
        int          dut;
        logic [3:0]  issue;
        logic [31:0] cnt;
        logic        stall;
        logic [31:0] busy;
        logic [31:0] sc;
    } exp_t;

    logic clk = 1'b0;
    logic rst, hold, flush;

    // 2-wide DUT
    logic [1:0]       valid2, u1_2, u2_2;
    control_t [1:0]   ctrl2;
    logic [1:0][4:0]  rs1_2, rs2_2, rd_2;
    logic [1:0]       issue2;
    logic [1:0]       cnt2;
    logic             stall2;
    logic [31:0]      busy2, sc2;

    // 4-wide DUT
    logic [3:0]       valid4, u1_4, u2_4;
    control_t [3:0]   ctrl4;
    logic [3:0][4:0]  rs1_4, rs2_4, rd_4;
    logic [3:0]       issue4;
    logic [2:0]       cnt4;
    logic             stall4;
    logic [31:0]      busy4, sc4;

    // Slot table written by the stimulus, copied onto a DUT at the negedge
    logic [3:0]       s_valid, s_u1, s_u2;
    control_t [3:0]   s_ctrl;
    logic [3:0][4:0]  s_rs1, s_rs2, s_rd;
    logic             s_rst, s_hold, s_flush;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    issue_ctrl_nw #(
        .ISSUE_W(2), .MEM_PORTS(1), .LOAD_STALL(1), .ALU_STALL(0), .CNT_W(3)
    ) u_dut2 (
        .clk(clk), .rst(rst), .valid_i(valid2), .ctrl_i(ctrl2),
        .rs1_i(rs1_2), .rs2_i(rs2_2), .rd_i(rd_2),
        .use_rs1_i(u1_2), .use_rs2_i(u2_2), .hold_i(hold), .flush_i(flush),
        .issue_o(issue2), .issue_cnt_o(cnt2), .stall_if_o(stall2),
        .busy_o(busy2), .stall_cycles_o(sc2)
    );

    issue_ctrl_nw #(
        .ISSUE_W(4), .MEM_PORTS(1), .LOAD_STALL(2), .ALU_STALL(0), .CNT_W(3)
    ) u_dut4 (
        .clk(clk), .rst(rst), .valid_i(valid4), .ctrl_i(ctrl4),
        .rs1_i(rs1_4), .rs2_i(rs2_4), .rd_i(rd_4),
        .use_rs1_i(u1_4), .use_rs2_i(u2_4), .hold_i(hold), .flush_i(flush),
        .issue_o(issue4), .issue_cnt_o(cnt4), .stall_if_o(stall4),
        .busy_o(busy4), .stall_cycles_o(sc4)
    );

    task automatic clear_slots();
        s_valid = '0; s_u1 = '0; s_u2 = '0; s_ctrl = '0;
        s_rs1 = '0; s_rs2 = '0; s_rd = '0;
    endtask

    task automatic set_slot(input int k, input kind_e kind, input int rd,
                            input int rs1, input int rs2);
        control_t c;
        logic u1, u2;
        c = '0; u1 = 1'b0; u2 = 1'b0;
        case (kind)
            K_ADD:   begin c.reg_write = 1'b1; u1 = 1'b1; u2 = 1'b1; end
            K_LW:    begin c.reg_write = 1'b1; c.mem_read = 1'b1; u1 = 1'b1; end
            K_SW:    begin c.mem_write = 1'b1; u1 = 1'b1; u2 = 1'b1; end
            K_BEQ:   begin c.branch = 1'b1; u1 = 1'b1; u2 = 1'b1; end
            K_JAL:   begin c.jump = 1'b1; c.reg_write = 1'b1; end
            K_LUI:   begin c.lui = 1'b1; c.reg_write = 1'b1; end
            K_ECALL: begin c.system = 1'b1; u1 = 1'b1; end  // reads a0-style operand
            default: ;
        endcase
        s_valid[k] = (kind != K_NOP);
        s_ctrl[k]  = c;
        s_u1[k]    = u1;
        s_u2[k]    = u2;
        s_rd[k]    = 5'(rd);
        s_rs1[k]   = 5'(rs1);
        s_rs2[k]   = 5'(rs2);
    endtask

    task automatic apply(input int sel);
        rst = s_rst; hold = s_hold; flush = s_flush;
        valid2 = '0; u1_2 = '0; u2_2 = '0; ctrl2 = '0; rs1_2 = '0; rs2_2 = '0; rd_2 = '0;
        valid4 = '0; u1_4 = '0; u2_4 = '0; ctrl4 = '0; rs1_4 = '0; rs2_4 = '0; rd_4 = '0;
        if (sel == 2) begin
            valid2 = s_valid[1:0]; u1_2 = s_u1[1:0]; u2_2 = s_u2[1:0]; ctrl2 = s_ctrl[1:0];
            rs1_2 = s_rs1[1:0]; rs2_2 = s_rs2[1:0]; rd_2 = s_rd[1:0];
        end else begin
            valid4 = s_valid; u1_4 = s_u1; u2_4 = s_u2; ctrl4 = s_ctrl;
            rs1_4 = s_rs1; rs2_4 = s_rs2; rd_4 = s_rd;
        end
    endtask

    task automatic push_exp(input string tag, input int dut, input logic [3:0] issue,
                            input logic stall, input logic [31:0] busy,
                            input logic [31:0] sc);
        exp_t e;
        e.dut   = dut;
        e.issue = issue;
        e.cnt   = 32'($countones(issue));
        e.stall = stall;
        e.busy  = busy;
        e.sc    = sc;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_one(input string tag, input string field,
                             input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, field, obs, expv);
        end
    endtask

    task automatic pop_check();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (e.dut == 2) begin
                check_one(t, "issue", 32'(issue2), 32'(e.issue));
                check_one(t, "cnt",   32'(cnt2),   e.cnt);
                check_one(t, "stall", 32'(stall2), 32'(e.stall));
                check_one(t, "busy",  busy2,       e.busy);
                check_one(t, "sc",    sc2,         e.sc);
            end else begin
                check_one(t, "issue", 32'(issue4), 32'(e.issue));
                check_one(t, "cnt",   32'(cnt4),   e.cnt);
                check_one(t, "stall", 32'(stall4), 32'(e.stall));
                check_one(t, "busy",  busy4,       e.busy);
                check_one(t, "sc",    sc4,         e.sc);
            end
        end
    endtask

    // One cycle: drive at the negedge, compare 1 ns later, clock edge follows.
    task automatic step(input string tag, input int dut, input logic [3:0] issue,
                        input logic stall, input logic [31:0] busy, input logic [31:0] sc);
        @(negedge clk);
        apply(dut);
        push_exp(tag, dut, issue, stall, busy, sc);
        #1;
        pop_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  t_issue [8];
        logic        t_stall [8];
        logic [31:0] t_busy  [8];
        logic [31:0] t_sc    [8];

        s_rst = 1'b1; s_hold = 1'b0; s_flush = 1'b0;
        clear_slots();
        apply(2);

        // Reset state with a ready instruction present
        set_slot(0, K_ADD, 1, 2, 3);
        step("rst2", 2, 4'b0000, 1'b0, 32'h0, 32'd0);
        step("rst4", 4, 4'b0000, 1'b0, 32'h0, 32'd0);
        s_rst = 1'b0;

        // ---------------- 2-wide instance, LOAD_STALL=1 ----------------
        clear_slots(); set_slot(0, K_ADD, 1, 2, 3); set_slot(1, K_ADD, 4, 5, 6);
        step("two_add", 2, 4'b0011, 1'b0, 32'h0, 32'd0);

        clear_slots(); set_slot(0, K_LW, 5, 1, 0); set_slot(1, K_ADD, 6, 5, 1);
        step("lw_use_c0", 2, 4'b0001, 1'b0, 32'h0, 32'd0);
        clear_slots(); set_slot(0, K_ADD, 6, 5, 1);
        step("lw_use_c1", 2, 4'b0000, 1'b1, 32'h20, 32'd0);
        step("lw_use_c2", 2, 4'b0001, 1'b0, 32'h0, 32'd1);

        clear_slots(); set_slot(0, K_LW, 5, 1, 0);
        step("hold_lw", 2, 4'b0001, 1'b0, 32'h0, 32'd1);
        clear_slots(); set_slot(0, K_ADD, 6, 5, 1);
        s_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("hold_%0d", i), 2, 4'b0000, 1'b0, 32'h20, 32'd1);
        end
        s_hold = 1'b0;
        step("hold_rel0", 2, 4'b0000, 1'b1, 32'h20, 32'd1);
        step("hold_rel1", 2, 4'b0001, 1'b0, 32'h0, 32'd2);

        clear_slots(); set_slot(0, K_BEQ, 0, 1, 2); set_slot(1, K_JAL, 1, 0, 0);
        step("beq_jal", 2, 4'b0001, 1'b0, 32'h0, 32'd2);
        clear_slots(); set_slot(0, K_ADD, 5, 1, 2); set_slot(1, K_ECALL, 0, 5, 0);
        step("add_ecall", 2, 4'b0011, 1'b0, 32'h0, 32'd2);

        clear_slots(); set_slot(0, K_ADD, 7, 1, 2);
        s_flush = 1'b1;
        step("flush", 2, 4'b0000, 1'b0, 32'h0, 32'd2);
        s_flush = 1'b0;

        clear_slots(); set_slot(0, K_ADD, 7, 1, 2); set_slot(1, K_LUI, 9, 0, 0);
        step("lui_slot1", 2, 4'b0001, 1'b0, 32'h0, 32'd2);
        clear_slots(); set_slot(0, K_LUI, 9, 0, 0); set_slot(1, K_ADD, 3, 1, 2);
        step("lui_slot0", 2, 4'b0011, 1'b0, 32'h0, 32'd2);
        clear_slots(); set_slot(0, K_ADD, 3, 1, 2); set_slot(1, K_ADD, 3, 4, 5);
        step("waw_group", 2, 4'b0001, 1'b0, 32'h0, 32'd2);
        clear_slots(); set_slot(0, K_LW, 0, 1, 0); set_slot(1, K_ADD, 7, 0, 0);
        step("x0_writer", 2, 4'b0011, 1'b0, 32'h0, 32'd2);
        clear_slots(); set_slot(0, K_ADD, 7, 0, 0); set_slot(1, K_SW, 0, 1, 7);
        step("raw_group", 2, 4'b0001, 1'b0, 32'h0, 32'd2);
        clear_slots(); set_slot(0, K_ECALL, 0, 1, 0); set_slot(1, K_ADD, 8, 1, 2);
        step("sys_barrier", 2, 4'b0001, 1'b0, 32'h0, 32'd2);
        clear_slots(); set_slot(1, K_ADD, 8, 1, 2);
        step("invalid_s0", 2, 4'b0000, 1'b0, 32'h0, 32'd2);

        // ---------------- 4-wide instance, LOAD_STALL=2 ----------------
        clear_slots();
        set_slot(0, K_ADD, 1, 2, 3); set_slot(1, K_SW, 0, 3, 2);
        set_slot(2, K_LW, 7, 4, 0);  set_slot(3, K_ADD, 8, 9, 10);
        step("mem_ports", 4, 4'b0011, 1'b0, 32'h0, 32'd0);
        clear_slots(); set_slot(0, K_LW, 7, 4, 0); set_slot(1, K_ADD, 8, 9, 10);
        step("mem_next", 4, 4'b0011, 1'b0, 32'h0, 32'd0);

        clear_slots(); set_slot(0, K_LW, 5, 1, 0); set_slot(1, K_ADD, 6, 5, 1);
        step("lw2_c0", 4, 4'b0001, 1'b0, 32'h80, 32'd0);
        clear_slots(); set_slot(0, K_ADD, 6, 5, 1);
        step("lw2_c1", 4, 4'b0000, 1'b1, 32'hA0, 32'd0);
        step("lw2_c2", 4, 4'b0000, 1'b1, 32'h20, 32'd1);
        step("lw2_c3", 4, 4'b0001, 1'b0, 32'h0, 32'd2);

        clear_slots(); set_slot(0, K_LW, 5, 1, 0);
        step("chain_lw", 4, 4'b0001, 1'b0, 32'h0, 32'd2);

        // LW x5,0(x5) repeated: two stall cycles, then it issues again.
        t_issue = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        t_stall = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        t_busy  = '{32'h20, 32'h20, 32'h0, 32'h20, 32'h20, 32'h0, 32'h20, 32'h20};
        t_sc    = '{32'd2, 32'd3, 32'd4, 32'd4, 32'd5, 32'd6, 32'd6, 32'd7};
        clear_slots(); set_slot(0, K_LW, 5, 5, 0);
        for (int i = 0; i < 8; i++) begin
            step($sformatf("chain_%0d", i), 4, t_issue[i], t_stall[i], t_busy[i], t_sc[i]);
        end

        // Asynchronous reset mid-cycle, well away from any clock edge
        #2;
        s_rst = 1'b1;
        rst   = 1'b1;
        push_exp("async_rst", 4, 4'b0000, 1'b0, 32'h0, 32'd0);
        #1;
        pop_check();
        s_rst = 1'b0;

        clear_slots(); set_slot(0, K_ADD, 6, 5, 5);
        step("post_rst", 4, 4'b0001, 1'b0, 32'h0, 32'd0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_ctrl_nw.md
Name: issue_ctrl_nw

Overview:
- Parametrised N-wide in-order issue controller for the superscalar pipeline; successor to the dual-issue combinational issue logic.
- Owns its scoreboard: per-register stall countdowns plus a load flag, so no external busy/load-pending vectors are needed.
- Sits between the decode slots and the EX lanes.
- Each cycle it produces a prefix-contiguous issue vector, a front-end stall, and a saturating stall-cycle counter.

Parameters:
- ISSUE_W, 2, number of decode/issue slots; slot 0 is oldest. Legal range 1..4.
- MEM_PORTS, 1, maximum memory ops issued per cycle.
- LOAD_STALL, 1, cycles a load's consumers must wait after issue; legal 1..7.
- ALU_STALL, 0, cycles an ALU/jump writer's consumers must wait after issue; legal 0..7.
- CNT_W, 3, scoreboard countdown width; must satisfy 2**CNT_W > max(LOAD_STALL, ALU_STALL).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- valid_i  in  ISSUE_W  slot holds a real instruction.
- ctrl_i  in  ISSUE_W x control_t  decoded control per slot.
- rs1_i, rs2_i, rd_i  in  ISSUE_W x 5  register indices per slot.
- use_rs1_i, use_rs2_i  in  ISSUE_W  slot reads rs1 / rs2.
- hold_i  in  1  backend frozen: no issue, scoreboard frozen.
- flush_i  in  1  redirect: suppress issue this cycle; scoreboard keeps counting.
- issue_o  out  ISSUE_W  per-slot issue grant; prefix form (0..k all 1, rest 0).
- issue_cnt_o  out  $clog2(ISSUE_W+1)  popcount of issue_o.
- stall_if_o  out  1  slot 0 valid and not issued, hold_i and flush_i both low.
- busy_o  out  32  per-register (cnt != 0), for debug/forwarding.
- stall_cycles_o  out  32  saturating count of cycles with stall_if_o = 1.

Behaviour:
- Reset:
  - All counters and load flags clear.
  - issue_o = 0, stall_cycles_o = 0, busy_o = 0.
- Validity qualifiers:
  - Operand used only if use_rsX && rsX != 0.
  - Write only if reg_write && rd != 0.
  - Invalid slots never issue; they also block every younger slot.
- Slot k (combinational) is eligible when all of the following hold:
  - Every used source has cnt == 0.
  - A writer must have cnt[rd] == 0 (WAW vs in-flight).
  - No older slot j<k in the same group writes a register slot k reads (no same-cycle forwarding).
  - No older slot j<k writes the same rd.
  - Memory ops in slots 0..k total at most MEM_PORTS.
  - At most one branch/jump among slots 0..k, and it may not be followed by another control-flow op.
  - If k>0 and the slot is LUI/AUIPC, it is ineligible. Lane restriction: LUI/AUIPC issue only in slot 0.
- Issue vector:
  - issue_o[k] = eligible[k] && issue_o[k-1] && !hold_i && !flush_i; issue_o[0] has no predecessor term.
  - In-order: a blocked slot blocks all younger slots.
- SYSTEM:
  - Issues if it is eligible and all older slots issue; it ignores register hazards.
  - Slots younger than a SYSTEM never issue in that cycle.
- WAR inside a group is not a hazard: all operands are read at issue.
- Scoreboard update (posedge), in this order:
  1. If hold_i, nothing changes.
  2. Otherwise every nonzero cnt decrements; the load flag clears when cnt reaches 0.
  3. Each issued writer then sets cnt[rd] = its stall value and load flag = mem_read. Only if the stall value > 0.
  4. A new issue to register r overrides the same-cycle decrement of r.
  5. Two same-group writers to one rd cannot both issue, since WAW blocks the younger.
- Counter behaviour: stall_cycles_o increments when stall_if_o is 1 and the counter is not at 0xFFFFFFFF; it saturates there.
- Reset mid-operation clears all state immediately; no issue occurs in the reset cycle.

Decomposition:
- rv32i_pkg gains:
  - ISSUE_W_DEF, LOAD_STALL_DEF, ALU_STALL_DEF.
  - A function returning the stall value for a control_t.
- control_t is reused unchanged.
- Sub-module reg_scoreboard:
  - Holds 32 counters and load flags, with freeze (hold), decrement, and up to ISSUE_W set ports.
  - Outputs busy and load-pending vectors.
- issue_ctrl_nw holds the hazard/prefix logic and the stall counter.

Test Plan:
1. Two independent ADDs (x1 = x2 + x3, x4 = x5 + x6), ISSUE_W=2 -> issue_o = 2'b11, issue_cnt_o = 2, stall_if_o = 0.
2. Slot0 LW x5, slot1 ADD x6 = x5 + x1 -> cycle0 issue_o = 01. Next cycle, with the ADD moved to slot0:
   - LOAD_STALL=1: stall_if_o = 1 for 1 cycle, then the ADD issues.
   - LOAD_STALL=2: stall_if_o = 1 for 2 cycles, then the ADD issues.
   - stall_cycles_o tracks the stall count.
3. hold_i = 1 for 3 cycles right after LW x5 issues -> busy_o[5] stays 1 throughout, issue_o = 0. The consumer issues exactly LOAD_STALL cycles after hold_i drops.
4. ISSUE_W=4, slots {ADD, SW, LW, ADD}, MEM_PORTS=1 -> issue_o = 4'b0011. Next cycle, with LW in slot0, LW and the ADD issue.
5. Slot0 BEQ, slot1 JAL -> issue_o = 01. Slot0 ADD, slot1 ECALL with a pending RAW on x5 -> issue_o = 11.
6. Assert rst asynchronously while busy_o = 0x20 (only x5 busy) and stall_cycles_o = 7 -> all outputs 0 in the same cycle; the first post-reset ADD x6 = x5 + x5 issues immediately.
